// File: rtl/cache_ctrl_burst.sv
// Direct-mapped write-through cache controller with burst line refill and optional write-allocate.
// Drives the tag/valid/data RAM enables and the system-bus handshakes; holds no cache data itself.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a processor read or write request
// RD_HIT  | read hit, completion pulse to the processor
// RD_ADDR | presenting the refill burst address on the read channel
// RD_FILL | accepting refill beats into the data RAM
// WR_REQ  | write-through address/data handshakes (independent)
// WR_RESP | waiting for the write response; updates data RAM on OKAY hit
module cache_ctrl_burst #(
   parameter int LINE_WORDS     = 4,
   parameter int WRITE_ALLOCATE = 0,
   parameter int IDX_W          = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       p_w_en,
   input  logic             p_r_en,
   input  logic             hit,
   input  logic             readAddr_ready,
   input  logic             readData_valid,
   input  logic             writeAddr_ready,
   input  logic             writeData_ready,
   input  logic             writeResp_valid,
   input  logic [31:0]      writeResp_msg,
   output logic             readAddr_valid,
   output logic             readData_ready,
   output logic             writeAddr_valid,
   output logic             writeData_valid,
   output logic             writeResp_ready,
   output logic [7:0]       readLen,
   output logic [IDX_W-1:0] refill_idx,
   output logic             dataram_sel,
   output logic             p_valid,
   output logic             p_err,
   output logic             w_tagram,
   output logic             w_validram,
   output logic             w_dataram,
   output logic             validin,
   output logic             busy
);

   typedef enum logic [2:0] {
      IDLE,
      RD_HIT,
      RD_ADDR,
      RD_FILL,
      WR_REQ,
      WR_RESP
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

   state_t           state, state_nxt;
   logic             pend_wr, pend_wr_nxt;
   logic             aw_done, aw_done_nxt;
   logic             w_done, w_done_nxt;
   logic             upd, upd_nxt;
   logic [IDX_W-1:0] cnt, cnt_nxt;
   logic             rd_req, wr_req;
   logic             aw_hs, w_hs;

   assign readLen = 8'(LINE_WORDS - 1);
   assign busy    = (state != IDLE);
   assign rd_req  = p_r_en;
   assign wr_req  = |p_w_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pend_wr <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         upd     <= 1'b0;
         cnt     <= '0;
      end else begin
         state   <= state_nxt;
         pend_wr <= pend_wr_nxt;
         aw_done <= aw_done_nxt;
         w_done  <= w_done_nxt;
         upd     <= upd_nxt;
         cnt     <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      pend_wr_nxt     = pend_wr;
      aw_done_nxt     = aw_done;
      w_done_nxt      = w_done;
      upd_nxt         = upd;
      cnt_nxt         = cnt;
      aw_hs           = 1'b0;
      w_hs            = 1'b0;
      readAddr_valid  = 1'b0;
      readData_ready  = 1'b0;
      writeAddr_valid = 1'b0;
      writeData_valid = 1'b0;
      writeResp_ready = 1'b0;
      refill_idx      = '0;
      dataram_sel     = 1'b0;
      p_valid         = 1'b0;
      p_err           = 1'b0;
      w_tagram        = 1'b0;
      w_validram      = 1'b0;
      w_dataram       = 1'b0;
      validin         = 1'b0;

      case (state)
         IDLE: begin
            // simultaneous read and write is malformed and dropped without a response
            if (rd_req && !wr_req) begin
               state_nxt = hit ? RD_HIT : RD_ADDR;
            end else if (wr_req && !rd_req) begin
               if (hit) begin
                  state_nxt = WR_REQ;
                  upd_nxt   = 1'b1;
               end else if (WRITE_ALLOCATE != 0) begin
                  state_nxt   = RD_ADDR;
                  pend_wr_nxt = 1'b1;
               end else begin
                  state_nxt = WR_REQ;
                  upd_nxt   = 1'b0;
               end
            end
         end

         RD_HIT: begin
            p_valid   = 1'b1;
            state_nxt = IDLE;
         end

         RD_ADDR: begin
            readAddr_valid = 1'b1;
            if (readAddr_ready) begin
               state_nxt = RD_FILL;
               cnt_nxt   = '0;
            end
         end

         RD_FILL: begin
            readData_ready = 1'b1;
            refill_idx     = cnt;
            if (readData_valid) begin
               w_dataram = 1'b1;
               // the line is invalid while partially overwritten; last beat revalidates it
               if (cnt == '0) begin
                  w_validram = 1'b1;
                  validin    = 1'b0;
               end
               if (cnt == LAST_IDX) begin
                  w_tagram   = 1'b1;
                  w_validram = 1'b1;
                  validin    = 1'b1;
                  if (pend_wr) begin
                     pend_wr_nxt = 1'b0;
                     upd_nxt     = 1'b1;
                     state_nxt   = WR_REQ;
                  end else begin
                     p_valid   = 1'b1;
                     state_nxt = IDLE;
                  end
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end

         WR_REQ: begin
            writeAddr_valid = !aw_done;
            writeData_valid = !w_done;
            aw_hs           = !aw_done && writeAddr_ready;
            w_hs            = !w_done && writeData_ready;
            if ((aw_done || aw_hs) && (w_done || w_hs)) begin
               state_nxt   = WR_RESP;
               aw_done_nxt = 1'b0;
               w_done_nxt  = 1'b0;
            end else begin
               aw_done_nxt = aw_done || aw_hs;
               w_done_nxt  = w_done || w_hs;
            end
         end

         WR_RESP: begin
            writeResp_ready = 1'b1;
            if (writeResp_valid) begin
               p_valid   = 1'b1;
               p_err     = |writeResp_msg;
               state_nxt = IDLE;
               if (upd && !(|writeResp_msg)) begin
                  dataram_sel = 1'b1;
                  w_dataram   = 1'b1;
               end
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_ctrl_burst.sv
// Bench for cache_ctrl_burst: two instances (bypass and write-allocate) driven by a reactive bus
// slave; expected timing is derived from handshake arithmetic over the driven stimulus.
module tb_cache_ctrl_burst;
   localparam int LW     = 4;
   localparam int BUDGET = 200;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  p_w_en0, p_w_en1;
   logic        p_r_en0, p_r_en1;
   logic        hit, rar, rdv, war, wdr, wrv;
   logic [31:0] wmsg;

   logic       rav[2], rdr[2], awv[2], wdv[2], wrr[2];
   logic [7:0] rlen[2];
   logic [1:0] ridx[2];
   logic       dsel[2], pv[2], perr[2], wtag[2], wval[2], wdat[2], vin[2], busy[2];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cache_ctrl_burst #(.LINE_WORDS(LW), .WRITE_ALLOCATE(0)) u_wa0 (
      .clk(clk), .rst(rst), .p_w_en(p_w_en0), .p_r_en(p_r_en0), .hit(hit),
      .readAddr_ready(rar), .readData_valid(rdv), .writeAddr_ready(war),
      .writeData_ready(wdr), .writeResp_valid(wrv), .writeResp_msg(wmsg),
      .readAddr_valid(rav[0]), .readData_ready(rdr[0]), .writeAddr_valid(awv[0]),
      .writeData_valid(wdv[0]), .writeResp_ready(wrr[0]), .readLen(rlen[0]),
      .refill_idx(ridx[0]), .dataram_sel(dsel[0]), .p_valid(pv[0]), .p_err(perr[0]),
      .w_tagram(wtag[0]), .w_validram(wval[0]), .w_dataram(wdat[0]), .validin(vin[0]),
      .busy(busy[0]));

   cache_ctrl_burst #(.LINE_WORDS(LW), .WRITE_ALLOCATE(1)) u_wa1 (
      .clk(clk), .rst(rst), .p_w_en(p_w_en1), .p_r_en(p_r_en1), .hit(hit),
      .readAddr_ready(rar), .readData_valid(rdv), .writeAddr_ready(war),
      .writeData_ready(wdr), .writeResp_valid(wrv), .writeResp_msg(wmsg),
      .readAddr_valid(rav[1]), .readData_ready(rdr[1]), .writeAddr_valid(awv[1]),
      .writeData_valid(wdv[1]), .writeResp_ready(wrr[1]), .readLen(rlen[1]),
      .refill_idx(ridx[1]), .dataram_sel(dsel[1]), .p_valid(pv[1]), .p_err(perr[1]),
      .w_tagram(wtag[1]), .w_validram(wval[1]), .w_dataram(wdat[1]), .validin(vin[1]),
      .busy(busy[1]));

   typedef struct {
      int         cyc;
      logic       dsel;
      logic [1:0] idx;
   } wd_t;

   // observations of one transaction
   wd_t  wd_q[$];
   logic vin_q[$];
   int   pv_cnt, pv_cyc, wtag_cnt, rav_cnt, rdr_cnt, awv_cnt, wdv_cnt, wrr_cnt;
   logic perr_obs;

   // reference expectations of one transaction
   wd_t  exp_wd[$];
   int   exp_beat_q[$];
   int   e_pv, e_rav, e_rdr, e_awv, e_wdv, e_wrr;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [14:0] outs(input int d);
      return {rav[d], rdr[d], awv[d], wdv[d], wrr[d], dsel[d], pv[d], perr[d],
              wtag[d], wval[d], wdat[d], vin[d], busy[d], ridx[d]};
   endfunction

   task automatic idle_inputs();
      p_w_en0 = 4'h0; p_w_en1 = 4'h0; p_r_en0 = 1'b0; p_r_en1 = 1'b0;
      hit = 1'b0; rar = 1'b0; rdv = 1'b0; war = 1'b0; wdr = 1'b0; wrv = 1'b0;
      wmsg = 32'h0;
   endtask

   task automatic idle_cycles(input int k);
      idle_inputs();
      repeat (k) @(negedge clk);
   endtask

   task automatic sample(input int d, input int n);
      wd_t e;
      if (pv[d]) begin
         pv_cnt++;
         pv_cyc   = n;
         perr_obs = perr[d];
      end
      if (wdat[d]) begin
         e.cyc = n; e.dsel = dsel[d]; e.idx = ridx[d];
         wd_q.push_back(e);
      end
      if (wval[d]) vin_q.push_back(vin[d]);
      if (wtag[d]) wtag_cnt++;
      rav_cnt += int'(rav[d]);
      rdr_cnt += int'(rdr[d]);
      awv_cnt += int'(awv[d]);
      wdv_cnt += int'(wdv[d]);
      wrr_cnt += int'(wrr[d]);
   endtask

   // kind: 0 read hit, 1 read miss, 2 write hit, 3 write miss bypass, 4 write miss allocate.
   // Cycle 0 is the IDLE cycle in which the request is first presented.
   task automatic run_txn(input int d, input int kind, input int ar, input int aw, input int w,
                          input int rsp, input logic [31:0] msg, input int gap,
                          input bit use_pat, input logic [31:0] pat, input int rst_beat);
      bit         done, rd, refill;
      int         mbeat, fill_start, last, ws, awh, wh, rs;
      logic [3:0] be;
      wd_t        e;
      wd_q.delete(); vin_q.delete(); exp_wd.delete(); exp_beat_q.delete();
      pv_cnt = 0; pv_cyc = -1; wtag_cnt = 0; perr_obs = 1'b0;
      rav_cnt = 0; rdr_cnt = 0; awv_cnt = 0; wdv_cnt = 0; wrr_cnt = 0;
      rd         = (kind <= 1);
      refill     = (kind == 1) || (kind == 4);
      fill_start = imax(1, ar) + 1;
      be         = 4'($urandom_range(1, 15));
      mbeat      = 0;
      done       = 1'b0;
      for (int n = 0; n <= BUDGET && !done; n++) begin
         if (d == 0) begin
            p_r_en0 = rd; p_w_en0 = rd ? 4'h0 : be;
         end else begin
            p_r_en1 = rd; p_w_en1 = rd ? 4'h0 : be;
         end
         hit  = (kind == 0) || (kind == 2);
         rar  = (n >= ar);
         war  = (n >= aw);
         wdr  = (n >= w);
         wrv  = (n >= rsp);
         wmsg = msg;
         rdv  = use_pat ? ((n < 32) ? pat[n] : 1'b1) : (32'($urandom_range(0, 99)) >= 32'(gap));
         rst  = 1'b0;
         if (refill && n >= fill_start && rdv && mbeat < LW) begin
            exp_beat_q.push_back(n);
            if (mbeat == rst_beat) begin
               rst  = 1'b1;
               done = 1'b1;
            end
            mbeat++;
         end
         #1;
         sample(d, n);
         if (pv[d]) done = 1'b1;
         @(negedge clk);
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL timeout kind=%0d: no p_valid within %0d cycles, required one", kind, BUDGET);
      end
      idle_inputs();

      last = (exp_beat_q.size() == LW) ? exp_beat_q[LW-1] : -2;
      e_pv = -1; e_rav = 0; e_rdr = 0; e_awv = 0; e_wdv = 0; e_wrr = 0;
      if (kind == 0) e_pv = 1;
      if (refill) begin
         e_rav = fill_start - 1;
         e_rdr = last - fill_start + 1;
      end
      if (kind == 1) e_pv = last;
      if (kind >= 2) begin
         ws    = (kind == 4) ? last + 1 : 1;
         awh   = imax(ws, aw);
         wh    = imax(ws, w);
         rs    = imax(awh, wh) + 1;
         e_pv  = imax(rs, rsp);
         e_awv = awh - ws + 1;
         e_wdv = wh - ws + 1;
         e_wrr = e_pv - rs + 1;
      end
      if (refill) begin
         for (int k = 0; k < exp_beat_q.size(); k++) begin
            e.cyc = exp_beat_q[k]; e.dsel = 1'b0; e.idx = 2'(k);
            exp_wd.push_back(e);
         end
      end
      if ((kind == 2 || kind == 4) && msg == 32'h0) begin
         e.cyc = e_pv; e.dsel = 1'b1; e.idx = 2'b00;
         exp_wd.push_back(e);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (3) @(negedge clk);
      #1;
      total++;
      if (outs(0) !== 15'h0 || outs(1) !== 15'h0) begin
         bad++;
         $display("FAIL reset_outs: got %h / %h, required 0", outs(0), outs(1));
      end
      total++;
      if (rlen[0] !== 8'd3 || rlen[1] !== 8'd3) begin
         bad++;
         $display("FAIL reset_readlen: got %0d / %0d, required 3", rlen[0], rlen[1]);
      end
      @(negedge clk);
      rst = 1'b0;
      idle_cycles(2);
   endtask

   task automatic test_read_miss();
      int  beat_c[4] = '{4, 5, 7, 8};
      bit  ok;
      // rdv pulses at cycles 0,1 precede RD_FILL and must be ignored; cycle 6 is a gap
      run_txn(0, 1, 3, 0, 0, 0, 32'h0, 0, 1'b1, 32'h0000_01B3, -1);
      total++;
      if (pv_cnt !== 1 || pv_cyc !== 8) begin
         bad++;
         $display("FAIL rmiss_pvalid: count=%0d cycle=%0d, required 1 at 8", pv_cnt, pv_cyc);
      end
      ok = (wd_q.size() == 4);
      for (int k = 0; k < wd_q.size() && k < 4; k++)
         if (wd_q[k].cyc != beat_c[k] || wd_q[k].idx != 2'(k) || wd_q[k].dsel != 1'b0) ok = 1'b0;
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL rmiss_beats: %0d data writes, required 4 at cycles 4,5,7,8 idx 0..3 sel 0",
                  wd_q.size());
      end
      total++;
      if (vin_q.size() != 2 || vin_q[0] !== 1'b0 || vin_q[1] !== 1'b1 || wtag_cnt != 1) begin
         bad++;
         $display("FAIL rmiss_valid: %0d valid writes, %0d tag writes, required validin 0 then 1, 1 tag",
                  vin_q.size(), wtag_cnt);
      end
      total++;
      if (rav_cnt !== 3 || rdr_cnt !== 5) begin
         bad++;
         $display("FAIL rmiss_bus: ar_valid cycles=%0d rd_ready cycles=%0d, required 3 and 5",
                  rav_cnt, rdr_cnt);
      end
      idle_cycles(1);
   endtask

   task automatic test_read_hit();
      run_txn(0, 0, 0, 0, 0, 0, 32'h0, 30, 1'b0, 32'h0, -1);
      total++;
      if (pv_cnt !== 1 || pv_cyc !== 1) begin
         bad++;
         $display("FAIL rhit_pvalid: count=%0d cycle=%0d, required 1 at 1", pv_cnt, pv_cyc);
      end
      total++;
      if (rav_cnt + rdr_cnt + awv_cnt + wdv_cnt + wrr_cnt != 0 || wd_q.size() != 0) begin
         bad++;
         $display("FAIL rhit_quiet: bus cycles=%0d ram writes=%0d, required 0",
                  rav_cnt + rdr_cnt + awv_cnt + wdv_cnt + wrr_cnt, wd_q.size());
      end
      idle_cycles(1);
   endtask

   task automatic test_write_split();
      run_txn(0, 2, 0, 4, 1, 0, 32'h0, 0, 1'b0, 32'h0, -1);
      total++;
      if (wdv_cnt !== 1 || awv_cnt !== 4) begin
         bad++;
         $display("FAIL wsplit_valids: wdata_valid cycles=%0d waddr_valid cycles=%0d, required 1 and 4",
                  wdv_cnt, awv_cnt);
      end
      total++;
      if (pv_cnt !== 1 || pv_cyc !== 5 || perr_obs !== 1'b0) begin
         bad++;
         $display("FAIL wsplit_pvalid: count=%0d cycle=%0d err=%b, required 1 at 5 err 0",
                  pv_cnt, pv_cyc, perr_obs);
      end
      total++;
      if (wd_q.size() != 1 || wd_q[0].cyc != 5 || wd_q[0].dsel !== 1'b1) begin
         bad++;
         $display("FAIL wsplit_ram: %0d data writes, required 1 at cycle 5 with sel 1", wd_q.size());
      end
      idle_cycles(1);
   endtask

   task automatic test_write_err();
      run_txn(0, 2, 1, 1, 1, 3, 32'h2, 0, 1'b0, 32'h0, -1);
      total++;
      if (pv_cnt !== 1 || pv_cyc !== 3 || perr_obs !== 1'b1) begin
         bad++;
         $display("FAIL werr_pvalid: count=%0d cycle=%0d err=%b, required 1 at 3 err 1",
                  pv_cnt, pv_cyc, perr_obs);
      end
      total++;
      if (wd_q.size() != 0 || vin_q.size() != 0 || wtag_cnt != 0) begin
         bad++;
         $display("FAIL werr_ram: data=%0d valid=%0d tag=%0d writes, required none",
                  wd_q.size(), vin_q.size(), wtag_cnt);
      end
      idle_cycles(1);
   endtask

   task automatic test_write_alloc();
      run_txn(1, 4, 1, 0, 0, 0, 32'h0, 0, 1'b1, 32'hFFFF_FFFF, -1);
      total++;
      if (pv_cnt !== 1 || pv_cyc !== 7) begin
         bad++;
         $display("FAIL walloc_pvalid: count=%0d cycle=%0d, required 1 at 7", pv_cnt, pv_cyc);
      end
      total++;
      if (wd_q.size() != 5 || rdr_cnt != 4 || wtag_cnt != 1) begin
         bad++;
         $display("FAIL walloc_ram: data writes=%0d fill cycles=%0d tag writes=%0d, required 5, 4, 1",
                  wd_q.size(), rdr_cnt, wtag_cnt);
      end
      idle_cycles(1);
      run_txn(0, 3, 0, 0, 0, 0, 32'h0, 0, 1'b0, 32'h0, -1);
      total++;
      if (rav_cnt + rdr_cnt != 0 || wd_q.size() != 0 || pv_cyc !== 2) begin
         bad++;
         $display("FAIL wbypass: read bus cycles=%0d data writes=%0d pvalid at %0d, required 0, 0, 2",
                  rav_cnt + rdr_cnt, wd_q.size(), pv_cyc);
      end
      idle_cycles(1);
   endtask

   task automatic test_both_ignored();
      int busy_seen = 0;
      int pv_seen   = 0;
      for (int n = 0; n < 6; n++) begin
         p_r_en0 = 1'b1; p_w_en0 = 4'hF; hit = n[0];
         #1;
         busy_seen += int'(busy[0]);
         pv_seen   += int'(pv[0]);
         @(negedge clk);
      end
      total++;
      if (busy_seen != 0 || pv_seen != 0) begin
         bad++;
         $display("FAIL both_ignored: busy cycles=%0d pvalid=%0d, required 0", busy_seen, pv_seen);
      end
      idle_cycles(1);
   endtask

   task automatic test_reset_midburst();
      run_txn(0, 1, 1, 0, 0, 0, 32'h0, 0, 1'b1, 32'hFFFF_FFFF, 2);
      rst = 1'b0;
      #1;
      total++;
      if (outs(0) !== 15'h0 || rlen[0] !== 8'd3) begin
         bad++;
         $display("FAIL rst_midburst_outs: got %h readLen=%0d, required 0 and 3", outs(0), rlen[0]);
      end
      total++;
      if (vin_q.size() != 1 || vin_q[$] !== 1'b0 || wd_q.size() != 3 || wtag_cnt != 0) begin
         bad++;
         $display("FAIL rst_midburst_ram: valid writes=%0d data writes=%0d tag=%0d, required 1 (validin 0), 3, 0",
                  vin_q.size(), wd_q.size(), wtag_cnt);
      end
      idle_cycles(2);
   endtask

   task automatic test_random();
      int          d, kind, ar, aw, w, rsp, gap;
      logic [31:0] msg;
      bit          ok, refill;
      for (int it = 0; it < 40; it++) begin
         d    = int'($urandom_range(0, 1));
         kind = int'($urandom_range(0, 3));
         if (kind == 3 && d == 1) kind = 4;
         ar   = int'($urandom_range(0, 4));
         aw   = int'($urandom_range(0, 6));
         w    = int'($urandom_range(0, 6));
         rsp  = int'($urandom_range(0, 9));
         gap  = int'($urandom_range(0, 50));
         msg  = ($urandom_range(0, 2) == 0) ? ($urandom() | 32'h1) : 32'h0;
         refill = (kind == 1) || (kind == 4);
         run_txn(d, kind, ar, aw, w, rsp, msg, gap, 1'b0, 32'h0, -1);
         total++;
         if (pv_cnt !== 1 || pv_cyc !== e_pv || perr_obs !== (kind >= 2 && msg != 0)) begin
            bad++;
            $display("FAIL rnd_pvalid it=%0d kind=%0d: count=%0d cycle=%0d err=%b, required 1 at %0d err %b",
                     it, kind, pv_cnt, pv_cyc, perr_obs, e_pv, (kind >= 2 && msg != 0));
         end
         total++;
         if (rav_cnt != e_rav || rdr_cnt != e_rdr || awv_cnt != e_awv ||
             wdv_cnt != e_wdv || wrr_cnt != e_wrr) begin
            bad++;
            $display("FAIL rnd_bus it=%0d kind=%0d: ar/rd/aw/w/b cycles %0d/%0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d/%0d",
                     it, kind, rav_cnt, rdr_cnt, awv_cnt, wdv_cnt, wrr_cnt,
                     e_rav, e_rdr, e_awv, e_wdv, e_wrr);
         end
         ok = (wd_q.size() == exp_wd.size());
         for (int k = 0; k < wd_q.size() && k < exp_wd.size(); k++)
            if (wd_q[k].cyc != exp_wd[k].cyc || wd_q[k].dsel !== exp_wd[k].dsel ||
                wd_q[k].idx !== exp_wd[k].idx) ok = 1'b0;
         total++;
         if (!ok) begin
            bad++;
            $display("FAIL rnd_dataram it=%0d kind=%0d: %0d data writes, required %0d with matching cycle/sel/idx",
                     it, kind, wd_q.size(), exp_wd.size());
         end
         total++;
         if (refill ? (vin_q.size() != 2 || vin_q[0] !== 1'b0 || vin_q[1] !== 1'b1 || wtag_cnt != 1)
                    : (vin_q.size() != 0 || wtag_cnt != 0)) begin
            bad++;
            $display("FAIL rnd_tagvalid it=%0d kind=%0d: valid writes=%0d tag writes=%0d, required %0d and %0d",
                     it, kind, vin_q.size(), wtag_cnt, refill ? 2 : 0, refill ? 1 : 0);
         end
         idle_cycles(int'($urandom_range(1, 2)));
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_read_miss();
      test_read_hit();
      test_write_split();
      test_write_err();
      test_write_alloc();
      test_both_ignored();
      test_reset_midburst();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
